// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with forwarding muxes, ALU decode, iterative signed multiplier and EX/MEM register.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  M_in,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUOp,
    input  logic        RegDst,
    input  logic [31:0] RDdata1,
    input  logic [31:0] RDdata2,
    input  logic [31:0] sign_extended,
    input  logic [4:0]  Inst_20_to_16,
    input  logic [4:0]  Inst_15_to_11,
    input  logic [5:0]  Inst_5_to_0,
    input  logic [1:0]  ForwardA,
    input  logic [1:0]  ForwardB,
    input  logic [31:0] MEM_WB_data,
    input  logic        flush,
    output logic        busy,
    output logic [1:0]  WB_out,
    output logic [1:0]  M_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] Store_data_out,
    output logic [4:0]  WriteReg_out,
    output logic        Zero_out
);
    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_next;
    logic [31:0] op_a, fwd_b, op_b, result, hi, lo, mcand, mplier;
    logic [63:0] acc, acc_sum, product;
    logic [4:0]  count;
    logic        sign, is_mult, start, last, bubble;

    always_comb begin
        op_a    = ForwardA == 2'b10 ? ALU_result_out : ForwardA == 2'b01 ? MEM_WB_data : RDdata1;
        fwd_b   = ForwardB == 2'b10 ? ALU_result_out : ForwardB == 2'b01 ? MEM_WB_data : RDdata2;
        op_b    = ALUSrc ? sign_extended : fwd_b;
        is_mult = ALUOp == 2'b10 && Inst_5_to_0 == 6'h18;
        start   = is_mult && !flush;
        last    = count == 5'd31;
        acc_sum = acc + (mplier[count] ? ({32'b0, mcand} << count) : 64'b0);
        product = sign ? -acc_sum : acc_sum;
        busy    = reset && ((state == IDLE && start) || (state == MUL && !last));
        bubble  = flush || busy || is_mult;
    end

    always_comb begin
        result = '0;
        case (ALUOp)
            2'b00: result = op_a + op_b;
            2'b01: result = op_a - op_b;
            2'b11: result = op_a | op_b;
            default:
                case (Inst_5_to_0)
                    6'h20: result = op_a + op_b;
                    6'h22: result = op_a - op_b;
                    6'h24: result = op_a & op_b;
                    6'h25: result = op_a | op_b;
                    6'h2A: result = {31'b0, $signed(op_a) < $signed(op_b)};
                    6'h10: result = hi;
                    6'h12: result = lo;
                    default: result = '0;
                endcase
        endcase
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && start)
            state_next = MUL;
        else if (state == MUL && last)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Operands are captured at start so forwarding changes mid-multiply are harmless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            acc   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= op_a[31] ? -op_a : op_a;
            mplier <= fwd_b[31] ? -fwd_b : fwd_b;
            sign   <= op_a[31] ^ fwd_b[31];
            acc    <= '0;
            count  <= '0;
        end else if (state == MUL) begin
            acc   <= acc_sum;
            count <= count + 5'd1;
            if (last)
                {hi, lo} <= product;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            WB_out         <= '0;
            M_out          <= '0;
            ALU_result_out <= '0;
            Store_data_out <= '0;
            WriteReg_out   <= '0;
            Zero_out       <= 1'b0;
        end else begin
            WB_out         <= bubble ? 2'b00 : WB_in;
            M_out          <= bubble ? 2'b00 : M_in;
            ALU_result_out <= result;
            Store_data_out <= fwd_b;
            WriteReg_out   <= RegDst ? Inst_15_to_11 : Inst_20_to_16;
            Zero_out       <= result == 32'b0;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_ex_stage;
    logic        clk = 0, reset = 0, ALUSrc = 0, RegDst = 0, flush = 0, busy;
    logic [1:0]  WB_in = 0, M_in = 0, ALUOp = 0, ForwardA = 0, ForwardB = 0, WB_out, M_out;
    logic [31:0] RDdata1 = 0, RDdata2 = 0, sign_extended = 0, MEM_WB_data = 0, ALU_result_out, Store_data_out;
    logic [4:0]  Inst_20_to_16 = 5'd3, Inst_15_to_11 = 5'd9, WriteReg_out;
    logic [5:0]  Inst_5_to_0 = 0;
    logic        Zero_out;

    typedef struct {
        string       nm;
        bit          cc, cd, cb;
        logic [1:0]  wb, m;
        logic [31:0] alu, st;
        logic [4:0]  wr;
        logic        z, b;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic bb;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .reset(reset), .WB_in(WB_in), .M_in(M_in), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .RegDst(RegDst), .RDdata1(RDdata1), .RDdata2(RDdata2), .sign_extended(sign_extended),
        .Inst_20_to_16(Inst_20_to_16), .Inst_15_to_11(Inst_15_to_11), .Inst_5_to_0(Inst_5_to_0),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .MEM_WB_data(MEM_WB_data), .flush(flush),
        .busy(busy), .WB_out(WB_out), .M_out(M_out), .ALU_result_out(ALU_result_out),
        .Store_data_out(Store_data_out), .WriteReg_out(WriteReg_out), .Zero_out(Zero_out)
    );

    task automatic step(input string nm, input bit cc, cd, cb, input logic [1:0] wb, m,
                        input logic [31:0] alu, st, input logic [4:0] wr, input logic z, b);
        exp_t x;
        x.nm = nm; x.cc = cc; x.cd = cd; x.cb = cb; x.wb = wb; x.m = m;
        x.alu = alu; x.st = st; x.wr = wr; x.z = z; x.b = b;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic ok(input string nm, input logic [1:0] wb, m, input logic [31:0] alu, st,
                      input logic [4:0] wr, input logic z);
        step(nm, 1, 1, 1, wb, m, alu, st, wr, z, 0);
    endtask

    task automatic mul_cyc(input string nm, input logic b);
        step(nm, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, b);
    endtask

    task automatic set(input logic [1:0] aop, input logic [5:0] fn, input logic [31:0] r1, r2);
        ALUOp = aop; Inst_5_to_0 = fn; RDdata1 = r1; RDdata2 = r2;
    endtask

    // Busy is sampled just before the edge, registered outputs just after it.
    initial forever begin
        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            e = q.pop_front();
            bb = busy;
            @(posedge clk);
            #1;
            if (e.cb) begin
                total++;
                if (bb !== e.b) begin
                    bad++;
                    $display("FAIL %s busy: got %b want %b", e.nm, bb, e.b);
                end
            end
            if (e.cc) begin
                total++;
                if ({WB_out, M_out} !== {e.wb, e.m}) begin
                    bad++;
                    $display("FAIL %s ctrl: got WB=%b M=%b want WB=%b M=%b", e.nm, WB_out, M_out, e.wb, e.m);
                end
            end
            if (e.cd) begin
                total++;
                if ({ALU_result_out, Store_data_out, WriteReg_out, Zero_out} !== {e.alu, e.st, e.wr, e.z}) begin
                    bad++;
                    $display("FAIL %s data: got alu=%h st=%h wr=%0d z=%b want alu=%h st=%h wr=%0d z=%b",
                             e.nm, ALU_result_out, Store_data_out, WriteReg_out, Zero_out, e.alu, e.st, e.wr, e.z);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            {WB_in, M_in, ALUOp, ForwardA, ForwardB} = 10'($urandom);
            {ALUSrc, RegDst, flush} = 3'($urandom);
            RDdata1 = $urandom; RDdata2 = $urandom; sign_extended = $urandom; MEM_WB_data = $urandom;
            Inst_5_to_0 = 6'($urandom); Inst_20_to_16 = 5'($urandom); Inst_15_to_11 = 5'($urandom);
            ok("reset", 0, 0, 0, 0, 0, 0);
        end
        reset = 1; flush = 0; ALUSrc = 0; ForwardA = 0; ForwardB = 0; M_in = 0;
        Inst_20_to_16 = 5'd3; Inst_15_to_11 = 5'd9;
        set(2'b10, 6'h20, 5, 100); ForwardB = 2'b01; MEM_WB_data = 7; RegDst = 1; WB_in = 2'b10;
        ok("fwd_add", 2'b10, 0, 12, 7, 9, 0);
        set(2'b11, 0, 0, 32'h55); ForwardA = 2'b10; ForwardB = 0; ALUSrc = 1; sign_extended = 32'h30; RegDst = 0;
        ok("fwd_exmem_or", 2'b10, 0, 32'h3C, 32'h55, 3, 0);
        set(2'b00, 0, 32'h1000, 32'hAB); ForwardA = 0; sign_extended = 32'hFFFFFFFC; M_in = 2'b10; WB_in = 2'b11;
        ok("lw_addr", 2'b11, 2'b10, 32'h0FFC, 32'hAB, 3, 0);
        set(2'b10, 6'h2A, 32'hFFFFFFFF, 1); ALUSrc = 0; M_in = 0; WB_in = 2'b10; RegDst = 1;
        ok("slt_neg", 2'b10, 0, 1, 1, 9, 0);
        set(2'b10, 6'h2A, 1, 32'hFFFFFFFF);
        ok("slt_pos", 2'b10, 0, 0, 32'hFFFFFFFF, 9, 1);
        set(2'b01, 0, 3, 3);
        ok("sub_zero", 2'b10, 0, 0, 3, 9, 1);
        set(2'b10, 6'h24, 32'hF0F0, 32'h3C3C);
        ok("and", 2'b10, 0, 32'h3030, 32'h3C3C, 9, 0);
        set(2'b10, 6'h3F, 5, 5);
        ok("bad_funct", 2'b10, 0, 0, 5, 9, 1);
        set(2'b10, 6'h22, 2, 5);
        ok("sub_wrap", 2'b10, 0, 32'hFFFFFFFD, 5, 9, 0);
        set(2'b10, 6'h20, 1, 1); flush = 1; WB_in = 2'b11; M_in = 2'b01;
        ok("flush", 0, 0, 2, 1, 9, 0);
        flush = 0; WB_in = 2'b10; M_in = 0;
        set(2'b10, 6'h18, 32'hFFFFFFF9, 6);
        for (int i = 0; i < 32; i++) mul_cyc("mult1_busy", 1);
        mul_cyc("mult1_retire", 0);
        set(2'b10, 6'h10, 0, 0);
        ok("mfhi1", 2'b10, 0, 32'hFFFFFFFF, 0, 9, 0);
        set(2'b10, 6'h12, 0, 0);
        ok("mflo1", 2'b10, 0, 32'hFFFFFFD6, 0, 9, 0);
        set(2'b10, 6'h18, 32'h7FFFFFFF, 32'h7FFFFFFF);
        for (int i = 0; i < 32; i++) begin
            flush = i >= 10 && i < 14;
            mul_cyc("mult2_busy", 1);
        end
        flush = 0;
        mul_cyc("mult2_retire", 0);
        set(2'b10, 6'h10, 0, 0);
        ok("mfhi2", 2'b10, 0, 32'h3FFFFFFF, 0, 9, 0);
        set(2'b10, 6'h18, 3, 3); flush = 1;
        mul_cyc("mult_flushed", 0);
        flush = 0;
        set(2'b10, 6'h12, 0, 0);
        ok("mflo2", 2'b10, 0, 1, 0, 9, 0);
        set(2'b10, 6'h18, 32'h12345, 32'h777);
        for (int i = 0; i < 11; i++) mul_cyc("mult3_busy", 1);
        reset = 0; set(2'b00, 0, 4, 4);
        ok("reset_mid_mult", 0, 0, 0, 0, 0, 0);
        reset = 1; set(2'b10, 6'h10, 0, 0);
        ok("hi_after_reset", 2'b10, 0, 0, 0, 9, 1);
        set(2'b10, 6'h12, 0, 0);
        ok("lo_after_reset", 2'b10, 0, 0, 0, 9, 1);
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
